// File: rtl/ctrl_decode_pipe_if.sv
// Handshake bundle between the IF/ID side and the execute-stage consumer of ctrl_decode_pipe.
// The master drives opcodes in and accepts control words out; the slave is the decode pipe.
interface ctrl_decode_pipe_if #(
    parameter int OP_W   = 6,
    parameter int CTRL_W = 13
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl;
    logic              out_illegal;

    modport master (
        output in_valid, op, out_ready,
        input  in_ready, out_valid, ctrl, out_illegal
    );

    modport slave (
        input  in_valid, op, out_ready,
        output in_ready, out_valid, ctrl, out_illegal
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Main opcode decoder followed by STAGES valid/ready slots with flush and illegal-opcode tracking.
// Defining CTRL_DECODE_PERF_EN adds the retired-entry and bubble performance counters.
module ctrl_decode_pipe #(
    parameter int STAGES = 1,
    parameter int OP_W   = 6,
    parameter int CTRL_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    ctrl_decode_pipe_if.slave bus,
    input  logic              flush,
    input  logic              clr_illegal,
    output logic              illegal_seen,
    output logic [OP_W-1:0]   illegal_op,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    if (CTRL_W != 13 || STAGES < 1 || STAGES > 4) begin : g_param_check
        $error("ctrl_decode_pipe: CTRL_W must be 13 and STAGES must be 1..4");
    end

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] load;
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [CTRL_W-1:0] ctrl_d [STAGES];
    logic              ill_q  [STAGES];
    logic              ill_d  [STAGES];
    logic [OP_W-1:0]   op_q   [STAGES];
    logic [OP_W-1:0]   op_d   [STAGES];

    logic              retire;
    logic              illegal_seen_q, illegal_seen_d;
    logic [OP_W-1:0]   illegal_op_q, illegal_op_d;

    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        case (bus.op)
            OP_W'(6'b000000): dec_ctrl = 13'b1010000000010;
            OP_W'(6'b100011): dec_ctrl = 13'b1001000100000;
            OP_W'(6'b101011): dec_ctrl = 13'b0001001000000;
            OP_W'(6'b000100): dec_ctrl = 13'b0000100000001;
            OP_W'(6'b000101): dec_ctrl = 13'b0000010000001;
            OP_W'(6'b001000): dec_ctrl = 13'b1001000000000;
            OP_W'(6'b000010): dec_ctrl = 13'b0000000010000;
            OP_W'(6'b100000): dec_ctrl = 13'b1001000100100;
            OP_W'(6'b000011): dec_ctrl = 13'b1100000001100;
            default:          dec_illegal = 1'b1;
        endcase
    end

    // A slot may load unless it and every slot downstream of it is full and the output is stalled.
    always_comb begin
        logic chain_full;
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            chain_full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                chain_full = chain_full & valid_q[j];
            end
            load[k] = !chain_full || bus.out_ready;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        op_d    = op_q;
        if (load[0]) begin
            valid_d[0] = bus.in_valid;
            ctrl_d[0]  = dec_ctrl;
            ill_d[0]   = dec_illegal;
            op_d[0]    = bus.op;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
                ill_d[k]   = ill_q[k-1];
                op_d[k]    = op_q[k-1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    assign bus.in_ready    = load[0];
    assign bus.out_valid   = valid_q[STAGES-1];
    assign bus.ctrl        = valid_q[STAGES-1] ? ctrl_q[STAGES-1] : '0;
    assign bus.out_illegal = valid_q[STAGES-1] && ill_q[STAGES-1];
    assign retire          = valid_q[STAGES-1] && bus.out_ready;

    // A retiring illegal entry beats a simultaneous clear, and then replaces the recorded opcode.
    always_comb begin
        illegal_seen_d = illegal_seen_q;
        illegal_op_d   = illegal_op_q;
        if (clr_illegal) begin
            illegal_seen_d = 1'b0;
            illegal_op_d   = '0;
        end
        if (retire && bus.out_illegal) begin
            illegal_seen_d = 1'b1;
            if (!illegal_seen_q || clr_illegal) begin
                illegal_op_d = op_q[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q        <= '0;
            illegal_seen_q <= 1'b0;
            illegal_op_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                ill_q[k]  <= 1'b0;
                op_q[k]   <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            illegal_seen_q <= illegal_seen_d;
            illegal_op_q   <= illegal_op_d;
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_d[k];
                ill_q[k]  <= ill_d[k];
                op_q[k]   <= op_d[k];
            end
        end
    end

    assign illegal_seen = illegal_seen_q;
    assign illegal_op   = illegal_op_q;

`ifdef CTRL_DECODE_PERF_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        instr_cnt_d  = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
        bubble_cnt_d = !bus.out_valid ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            instr_cnt_q  <= instr_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign instr_cnt  = instr_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign instr_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe at STAGES=2, CNT_W=4: vector tables for streaming,
// back-pressure and flush, plus hand sequences for illegal tracking, reset and counter wrap.
module tb_ctrl_decode_pipe;

    localparam int STAGES = 2;
    localparam int OP_W   = 6;
    localparam int CTRL_W = 13;
    localparam int CNT_W  = 4;

`ifdef CTRL_DECODE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0]  OP_LW     = 6'b100011;
    localparam logic [5:0]  OP_SW     = 6'b101011;
    localparam logic [5:0]  OP_ADDI   = 6'b001000;
    localparam logic [12:0] CTRL_LW   = 13'b1001000100000;
    localparam logic [12:0] CTRL_SW   = 13'b0001001000000;
    localparam logic [12:0] CTRL_ADDI = 13'b1001000000000;

    localparam logic [5:0] OP_TAB [9] = '{
        6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
        6'b001000, 6'b000010, 6'b100000, 6'b000011};
    localparam logic [12:0] CTRL_TAB [9] = '{
        13'b1010000000010, 13'b1001000100000, 13'b0001001000000,
        13'b0000100000001, 13'b0000010000001, 13'b1001000000000,
        13'b0000000010000, 13'b1001000100100, 13'b1100000001100};

    typedef struct {
        logic        in_valid;
        logic [5:0]  op;
        logic        out_ready;
        logic        flush;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [12:0] exp_ctrl;
        logic        exp_illegal;
    } vec_t;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             clr_illegal;
    logic             illegal_seen;
    logic [OP_W-1:0]  illegal_op;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int   n_checks;
    int   n_fails;
    vec_t vecs [$];

    ctrl_decode_pipe_if #(.OP_W(OP_W), .CTRL_W(CTRL_W)) bus ();

    ctrl_decode_pipe #(
        .STAGES(STAGES),
        .OP_W  (OP_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .flush       (flush),
        .clr_illegal (clr_illegal),
        .illegal_seen(illegal_seen),
        .illegal_op  (illegal_op),
        .instr_cnt   (instr_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic iv, input logic [5:0] op, input logic ordy,
                                input logic fl, input logic ir, input logic ov,
                                input logic [12:0] c);
        vec_t v;
        v.in_valid      = iv;
        v.op            = op;
        v.out_ready     = ordy;
        v.flush         = fl;
        v.exp_in_ready  = ir;
        v.exp_out_valid = ov;
        v.exp_ctrl      = c;
        v.exp_illegal   = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [5:0] op, input logic ordy,
                                 input logic fl, input logic clr);
        bus.in_valid  = iv;
        bus.op        = op;
        bus.out_ready = ordy;
        flush         = fl;
        clr_illegal   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Outputs are checked against the state left by the previous edge, before this cycle's edge.
    task automatic runVectors(input string tag);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in_valid, vecs[i].op, vecs[i].out_ready, vecs[i].flush, 1'b0);
            #1;
            checkOutput($sformatf("%s[%0d].in_ready", tag, i), 32'(bus.in_ready), 32'(vecs[i].exp_in_ready));
            checkOutput($sformatf("%s[%0d].out_valid", tag, i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
            checkOutput($sformatf("%s[%0d].ctrl", tag, i), 32'(bus.ctrl), 32'(vecs[i].exp_ctrl));
            checkOutput($sformatf("%s[%0d].out_illegal", tag, i), 32'(bus.out_illegal), 32'(vecs[i].exp_illegal));
            tick();
        end
        vecs.delete();
    endtask

    task automatic pushIllegal(input logic [5:0] op, input logic clr_at_retire);
        applyStimulus(1'b1, op, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("illegal.out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("illegal.ctrl", 32'(bus.ctrl), 32'd0);
        checkOutput("illegal.out_illegal", 32'(bus.out_illegal), 32'd1);
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, clr_at_retire);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_n  = 1'b0;
        applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

        doReset();
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset.ctrl", 32'(bus.ctrl), 32'd0);
        checkOutput("reset.illegal_seen", 32'(illegal_seen), 32'd0);
        checkOutput("reset.illegal_op", 32'(illegal_op), 32'd0);
        checkOutput("reset.instr_cnt", 32'(instr_cnt), 32'd0);
        checkOutput("reset.bubble_cnt", 32'(bubble_cnt), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("idle.bubble_cnt", 32'(bubble_cnt), PERF ? 32'd3 : 32'd0);

        // Full-rate stream of every legal opcode; output trails input by two cycles.
        doReset();
        for (int i = 0; i < 12; i++) begin
            vecs.push_back(mk(i < 9, (i < 9) ? OP_TAB[i] : 6'd0, 1'b1, 1'b0, 1'b1,
                              (i >= 2 && i <= 10), (i >= 2 && i <= 10) ? CTRL_TAB[i-2] : 13'd0));
        end
        runVectors("stream");
        checkOutput("stream.instr_cnt", 32'(instr_cnt), PERF ? 32'd9 : 32'd0);

        // Stalled consumer: two accepts fill the pipe, third waits, order preserved on release.
        doReset();
        vecs.push_back(mk(1, OP_LW,   0, 0, 1, 0, 13'd0));
        vecs.push_back(mk(1, OP_SW,   0, 0, 1, 0, 13'd0));
        vecs.push_back(mk(1, OP_ADDI, 0, 0, 0, 1, CTRL_LW));
        vecs.push_back(mk(1, OP_ADDI, 0, 0, 0, 1, CTRL_LW));
        vecs.push_back(mk(1, OP_ADDI, 0, 0, 0, 1, CTRL_LW));
        vecs.push_back(mk(1, OP_ADDI, 1, 0, 1, 1, CTRL_LW));
        vecs.push_back(mk(0, 6'd0,    1, 0, 1, 1, CTRL_SW));
        vecs.push_back(mk(0, 6'd0,    1, 0, 1, 1, CTRL_ADDI));
        vecs.push_back(mk(0, 6'd0,    1, 0, 1, 0, 13'd0));
        runVectors("stall");

        // Flush with two entries in flight; the ADDI offered alongside flush must never emerge.
        doReset();
        vecs.push_back(mk(1, OP_LW,   0, 0, 1, 0, 13'd0));
        vecs.push_back(mk(1, OP_SW,   0, 0, 1, 0, 13'd0));
        vecs.push_back(mk(1, OP_ADDI, 0, 1, 0, 1, CTRL_LW));
        vecs.push_back(mk(0, 6'd0,    1, 0, 1, 0, 13'd0));
        vecs.push_back(mk(0, 6'd0,    1, 0, 1, 0, 13'd0));
        vecs.push_back(mk(0, 6'd0,    1, 0, 1, 0, 13'd0));
        runVectors("flush");

        doReset();
        pushIllegal(6'b111111, 1'b0);
        checkOutput("ill1.illegal_seen", 32'(illegal_seen), 32'd1);
        checkOutput("ill1.illegal_op", 32'(illegal_op), 32'h3f);
        pushIllegal(6'b010000, 1'b0);
        checkOutput("ill2.illegal_seen", 32'(illegal_seen), 32'd1);
        checkOutput("ill2.illegal_op", 32'(illegal_op), 32'h3f);
        pushIllegal(6'b010000, 1'b1);
        checkOutput("clr_and_set.illegal_seen", 32'(illegal_seen), 32'd1);
        checkOutput("clr_and_set.illegal_op", 32'(illegal_op), 32'h10);
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("clr.illegal_seen", 32'(illegal_seen), 32'd0);
        checkOutput("clr.illegal_op", 32'(illegal_op), 32'd0);

        // Reset while two valid entries sit in a stalled pipe and the sticky flag is set.
        doReset();
        pushIllegal(6'b111111, 1'b0);
        applyStimulus(1'b1, OP_LW, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OP_SW, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("pre_reset.out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre_reset.illegal_seen", 32'(illegal_seen), 32'd1);
        reset_n = 1'b0;
        applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mid_reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_reset.ctrl", 32'(bus.ctrl), 32'd0);
        checkOutput("mid_reset.in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid_reset.illegal_seen", 32'(illegal_seen), 32'd0);
        checkOutput("mid_reset.illegal_op", 32'(illegal_op), 32'd0);
        checkOutput("mid_reset.instr_cnt", 32'(instr_cnt), 32'd0);
        checkOutput("mid_reset.bubble_cnt", 32'(bubble_cnt), 32'd0);
        reset_n = 1'b1;

        // Twenty retires wrap a 4-bit counter to 4.
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, OP_TAB[i % 9], 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("wrap.instr_cnt", 32'(instr_cnt), PERF ? 32'd4 : 32'd0);
        checkOutput("wrap.out_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
